rca_serial_add_ctrl: RTL and testbench

- Sequencing controller that performs a WIDTH-bit add or subtract by time-multiplexing one rca_4_bit slice, one nibble per clock, LSB nibble first.
- Holds the operand registers, the inter-nibble carry register, the nibble index counter and the result register.
- Used where area matters more than latency, for example in the lab ALU datapath; it replaces a WIDTH-bit ripple chain.

---
 rtl/rca_serial_add_ctrl.sv | 144 ++++++++++++++
 tb/tb_rca_serial_add_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/rca_serial_add_ctrl.sv
// Serial add/subtract controller: one 4-bit ripple slice reused per nibble,
// LSB nibble first, with registered result, carry-out and signed overflow.

module rca_4_bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];

endmodule

module rca_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
    $error("rca_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 8");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [IW-1:0]    idx;

  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic [3:0] s_nib;
  logic       s_cout;
  logic       last;

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == IW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
  end

  assign last = (idx == IW'(N - 1));

  rca_4_bit u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry),
    .sum  (s_nib),
    .cout (s_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            sum   <= '0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < N; i++) begin
            if (idx == IW'(i)) sum[4*i +: 4] <= s_nib;
          end
          carry <= s_cout;
          if (last) begin
            // B' already carries the subtract inversion, so one rule serves both
            cout     <= s_cout;
            overflow <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                        (s_nib[3] != a_q[WIDTH-1]);
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca_serial_add_ctrl.sv
// Directed bench for rca_serial_add_ctrl (WIDTH=16): timing, results,
// held start, and asynchronous reset mid-operation.

module tb_rca_serial_add_ctrl;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int total;
  int bad;
  logic pc;
  logic pv;

  rca_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic vs, input logic vc,
                       input logic [W-1:0] es, input logic ec,
                       input logic ev);
    logic [W-1:0] m;
    @(negedge clk);
    a = va; b = vb; sub = vs; cin = vc; start = 1'b1;
    for (int k = 1; k <= N; k++) begin
      @(negedge clk);
      start = 1'b0;
      a = ~va; b = ~vb; sub = ~vs; cin = ~vc;
      m = (W'(1) << (4 * (k - 1))) - W'(1);
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_done", 32'(done), 32'd0);
      chk("run_sum", 32'(sum), 32'(es & m));
      chk("run_cout_hold", 32'(cout), 32'(pc));
      chk("run_ovf_hold", 32'(overflow), 32'(pv));
    end
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("sum", 32'(sum), 32'(es));
    chk("cout", 32'(cout), 32'(ec));
    chk("ovf", 32'(overflow), 32'(ev));
    @(negedge clk);
    chk("done_drop", 32'(done), 32'd0);
    chk("sum_hold", 32'(sum), 32'(es));
    pc = ec;
    pv = ev;
  endtask

  initial begin
    total = 0; bad = 0; pc = 1'b0; pv = 1'b0;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);

    // abort after two RUN cycles; flags are nonzero beforehand
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_sum", 32'(sum), 32'h0055);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_sum", 32'(sum), 32'd0);
    chk("arst_cout", 32'(cout), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
    pc = 1'b0; pv = 1'b0;

    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    // start held high: accepts at edges 0 and N+2 only
    @(negedge clk);
    sub = 1'b0; cin = 1'b0; b = 16'h0001; start = 1'b1;
    for (int t = 0; t < 12; t++) begin
      if (t == 0) a = 16'h0100;
      else if (t == N + 2) a = 16'h0200;
      else a = 16'hF0F0 + 16'(t);
      @(negedge clk);
      chk("held_done", 32'(done),
          32'((t == N) || (t == 2 * N + 2)));
      if (t == N) chk("held_sum0", 32'(sum), 32'h0101);
      if (t == 2 * N + 2) chk("held_sum1", 32'(sum), 32'h0201);
    end
    start = 1'b0;
    @(negedge clk);
    chk("held_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
